// File: rtl/piton_dcr_seq_ctrl_if.sv
// Signal bundle between piton_dcr_seq_ctrl and its surroundings: host table/launch,
// Vortex DCR buffer push/ack, and Vortex start/busy/status.
interface piton_dcr_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cfg_wr_valid;
    logic [2:0]            cfg_wr_idx;
    logic [ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [DATA_WIDTH-1:0] cfg_wr_data;
    logic                  launch_valid;
    logic [3:0]            launch_count;
    logic                  launch_ready;
    logic                  buffer_wr_valid;
    logic [ADDR_WIDTH-1:0] buffer_wr_addr;
    logic [DATA_WIDTH-1:0] buffer_wr_data;
    logic                  buffer_full;
    logic                  dcr_ack;
    logic                  vx_start;
    logic                  vx_busy;
    logic                  done;
    logic                  done_clr;
    logic                  timeout_err;
    logic [2:0]            seq_state;

    // Sequencer side
    modport master (
        input  cfg_wr_valid, cfg_wr_idx, cfg_wr_addr, cfg_wr_data,
        input  launch_valid, launch_count,
        output launch_ready,
        output buffer_wr_valid, buffer_wr_addr, buffer_wr_data,
        input  buffer_full, dcr_ack,
        output vx_start,
        input  vx_busy,
        output done,
        input  done_clr,
        output timeout_err, seq_state
    );

    // Host / DCR buffer / Vortex side
    modport slave (
        output cfg_wr_valid, cfg_wr_idx, cfg_wr_addr, cfg_wr_data,
        output launch_valid, launch_count,
        input  launch_ready,
        input  buffer_wr_valid, buffer_wr_addr, buffer_wr_data,
        output buffer_full, dcr_ack,
        input  vx_start,
        output vx_busy,
        input  done,
        output done_clr,
        input  timeout_err, seq_state
    );
endinterface

// File: rtl/piton_dcr_seq_ctrl.sv
// Replays a host-programmed table of up to 8 DCR writes into the Vortex DCR buffer, then
// starts Vortex and waits for it to finish. Define PITON_DCR_SEQ_TIMEOUT_EN for a RUN watchdog.
module piton_dcr_seq_ctrl #(
    parameter int VX_DCR_ADDR_WIDTH = 8,
    parameter int VX_DCR_DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING   = 6,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input logic                  clk,
    input logic                  rst,
    piton_dcr_seq_ctrl_if.master bus
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("piton_dcr_seq_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        DRAIN = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OUT_LIMIT = 3'(MAX_OUTSTANDING);

    state_t state;
    state_t state_next;

    logic [VX_DCR_ADDR_WIDTH-1:0] tbl_addr [8];
    logic [VX_DCR_DATA_WIDTH-1:0] tbl_data [8];

    logic [3:0] count;
    logic [3:0] ptr;
    logic [3:0] launch_n;
    logic [2:0] outstanding;
    logic [2:0] outstanding_next;
    logic       busy_seen;
    logic       push;
    logic       ack_hit;
    logic       last_push;
    logic       run_complete;
    logic       table_wr_en;
    logic       timeout_hit;
    logic       timeout_flag;

    assign launch_n     = (bus.launch_count > 4'd8) ? 4'd8 : bus.launch_count;
    assign push         = (state == PUSH) && !bus.buffer_full && (outstanding < OUT_LIMIT);
    assign ack_hit      = bus.dcr_ack && (outstanding != 3'd0);
    assign last_push    = push && (ptr == count - 4'd1);
    assign run_complete = (state == RUN) && busy_seen && !bus.vx_busy;
    assign table_wr_en  = bus.cfg_wr_valid && ((state == IDLE) || (state == DONE));

    always_comb begin
        outstanding_next = outstanding;
        if (push && !ack_hit) begin
            outstanding_next = outstanding + 3'd1;
        end else if (!push && ack_hit) begin
            outstanding_next = outstanding - 3'd1;
        end
    end

`ifdef PITON_DCR_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timer;

    // Timer counts RUN cycles; the TIMEOUT_CYCLES-th RUN cycle without completion fires
    assign timeout_hit = (state == RUN) && !run_complete && (timer == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == START) begin
                timer <= 16'd0;
            end else if (state == RUN) begin
                timer <= timer + 16'd1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if ((state == DONE) && bus.done_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.launch_valid) begin
                    state_next = (launch_n == 4'd0) ? START : PUSH;
                end
            end
            PUSH: begin
                if (last_push) begin
                    state_next = DRAIN;
                end
            end
            // Leaving on the final ack lets vx_start follow it by exactly one cycle
            DRAIN: begin
                if (outstanding_next == 3'd0) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = RUN;
            end
            RUN: begin
                if (run_complete || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.done_clr) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= 4'd0;
            ptr         <= 4'd0;
            outstanding <= 3'd0;
            busy_seen   <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if ((state == IDLE) && bus.launch_valid) begin
                count <= launch_n;
                ptr   <= 4'd0;
            end else if (push) begin
                ptr <= ptr + 4'd1;
            end
            // busy seen during START is discarded so only RUN-cycle activity counts
            if (state == START) begin
                busy_seen <= 1'b0;
            end else if ((state == RUN) && bus.vx_busy) begin
                busy_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (table_wr_en) begin
            tbl_addr[bus.cfg_wr_idx] <= bus.cfg_wr_addr;
            tbl_data[bus.cfg_wr_idx] <= bus.cfg_wr_data;
        end
    end

    assign bus.launch_ready    = (state == IDLE);
    assign bus.buffer_wr_valid = push;
    assign bus.buffer_wr_addr  = (state == PUSH) ? tbl_addr[ptr[2:0]] : '0;
    assign bus.buffer_wr_data  = (state == PUSH) ? tbl_data[ptr[2:0]] : '0;
    assign bus.vx_start        = (state == START);
    assign bus.done            = (state == DONE);
    assign bus.timeout_err     = timeout_flag;
    assign bus.seq_state       = state;

endmodule

// File: tb/tb_piton_dcr_seq_ctrl.sv
// Self-checking bench for piton_dcr_seq_ctrl: directed and randomized launches compared
// cycle by cycle against a behavioural model of the sequencing rules.
module tb_piton_dcr_seq_ctrl;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int MAX_OUT = 6;
`ifdef PITON_DCR_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
    localparam bit TO_EN      = 1'b1;
`else
    localparam int TB_TIMEOUT = 65535;
    localparam bit TO_EN      = 1'b0;
`endif

    localparam int PH_IDLE   = 0;
    localparam int PH_SEND   = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_KICK   = 3;
    localparam int PH_KERNEL = 4;
    localparam int PH_FIN    = 5;

    logic clk = 1'b0;
    logic rst;

    piton_dcr_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    piton_dcr_seq_ctrl #(
        .VX_DCR_ADDR_WIDTH(AW),
        .VX_DCR_DATA_WIDTH(DW),
        .MAX_OUTSTANDING  (MAX_OUT),
        .TIMEOUT_CYCLES   (TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model state
    logic [AW-1:0] m_addr [8];
    logic [DW-1:0] m_data [8];
    int ph, m_n, m_sent, m_out, m_run;
    bit m_seen, m_terr;
    int ack_q [$];

    // Stimulus policy
    int full_mode, full_lo, full_hi, ack_mode, ack_delay, ack_hold;
    int busy_delay, busy_len;
    bit busy_in_start, noise;

    // Observations
    int seq_start, pushes_obs, probe_cyc, pushes_at_probe;
    int last_ack_cyc, start_cyc, first_push_cyc, launch_cyc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        ph = PH_IDLE; m_n = 0; m_sent = 0; m_out = 0; m_run = 0;
        m_seen = 1'b0; m_terr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        ack_q.delete();
    endtask

    task automatic idleInputs();
        bus.cfg_wr_valid = 1'b0; bus.cfg_wr_idx = 3'd0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.launch_valid = 1'b0; bus.launch_count = 4'd0;
        bus.buffer_full = 1'b0; bus.dcr_ack = 1'b0; bus.vx_busy = 1'b0; bus.done_clr = 1'b0;
    endtask

    task automatic modelUpdate(input bit push);
        bit ackv;
        int out_after;
        ackv = bus.dcr_ack && (m_out > 0);
        out_after = m_out + (push ? 1 : 0) - (ackv ? 1 : 0);
        if (push) ack_q.push_back((cyc + ack_delay > ack_hold) ? cyc + ack_delay : ack_hold);
        if ((ph == PH_IDLE || ph == PH_FIN) && bus.cfg_wr_valid) begin
            m_addr[bus.cfg_wr_idx] = bus.cfg_wr_addr;
            m_data[bus.cfg_wr_idx] = bus.cfg_wr_data;
        end
        case (ph)
            PH_IDLE: if (bus.launch_valid) begin
                m_n = (bus.launch_count > 4'd8) ? 8 : int'(bus.launch_count);
                m_sent = 0;
                launch_cyc = cyc;
                ph = (m_n == 0) ? PH_KICK : PH_SEND;
            end
            PH_SEND: if (push) begin
                m_sent++;
                if (m_sent == m_n) ph = PH_WAIT;
            end
            PH_WAIT: if (out_after == 0) ph = PH_KICK;
            PH_KICK: begin
                m_seen = 1'b0;
                m_run = 0;
                ph = PH_KERNEL;
            end
            PH_KERNEL: begin
                m_run++;
                if (m_seen && !bus.vx_busy) begin
                    ph = PH_FIN;
                end else begin
                    if (bus.vx_busy) m_seen = 1'b1;
                    if (TO_EN && m_run == TB_TIMEOUT) begin
                        ph = PH_FIN;
                        m_terr = 1'b1;
                    end
                end
            end
            PH_FIN: if (bus.done_clr) begin
                ph = PH_IDLE;
                m_terr = 1'b0;
            end
            default: ;
        endcase
        m_out = out_after;
    endtask

    task automatic stepCycle();
        bit exp_push;
        #1;
        exp_push = (ph == PH_SEND) && !bus.buffer_full && (m_out < MAX_OUT);
        checkOutput("launch_ready", 32'(bus.launch_ready), 32'(ph == PH_IDLE));
        checkOutput("buffer_wr_valid", 32'(bus.buffer_wr_valid), 32'(exp_push));
        if (ph == PH_SEND) begin
            checkOutput("buffer_wr_addr", 32'(bus.buffer_wr_addr), 32'(m_addr[m_sent]));
            checkOutput("buffer_wr_data", bus.buffer_wr_data, m_data[m_sent]);
        end
        checkOutput("vx_start", 32'(bus.vx_start), 32'(ph == PH_KICK));
        checkOutput("done", 32'(bus.done), 32'(ph == PH_FIN));
        checkOutput("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        checkOutput("seq_state", 32'(bus.seq_state), 32'(ph));
        if (bus.buffer_wr_valid === 1'b1) begin
            pushes_obs++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        if (bus.dcr_ack) last_ack_cyc = cyc;
        if (bus.vx_start === 1'b1) start_cyc = cyc;
        if (cyc == probe_cyc) pushes_at_probe = pushes_obs;
        modelUpdate(exp_push);
        cyc++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit want_launch, input logic [3:0] count);
        int rel;
        rel = cyc - seq_start;
        case (full_mode)
            1:       bus.buffer_full = (rel >= full_lo) && (rel < full_hi);
            2:       bus.buffer_full = ($urandom_range(0, 3) == 0);
            default: bus.buffer_full = 1'b0;
        endcase
        if (ack_mode == 0) begin
            if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
                bus.dcr_ack = 1'b1;
                void'(ack_q.pop_front());
            end else begin
                bus.dcr_ack = 1'b0;
            end
        end else begin
            bus.dcr_ack = (m_out > 0) && ($urandom_range(0, 1) == 1);
        end
        bus.vx_busy = (ph == PH_KICK) ? busy_in_start :
                      (ph == PH_KERNEL) ? (m_run >= busy_delay && m_run < busy_delay + busy_len) : 1'b0;
        if (ph == PH_IDLE) begin
            bus.launch_valid = want_launch;
            bus.launch_count = count;
        end else begin
            bus.launch_valid = noise && ($urandom_range(0, 3) == 0);
            bus.launch_count = 4'($urandom_range(0, 15));
        end
        bus.done_clr = (ph == PH_FIN) ? ($urandom_range(0, 2) == 0) : (noise && ($urandom_range(0, 3) == 0));
        bus.cfg_wr_valid = noise && ($urandom_range(0, 3) == 0);
        bus.cfg_wr_idx   = 3'($urandom_range(0, 7));
        bus.cfg_wr_addr  = AW'($urandom);
        bus.cfg_wr_data  = $urandom;
    endtask

    task automatic runSequence(input logic [3:0] count);
        bit started;
        bit finished;
        int exp_n;
        started = 1'b0;
        finished = 1'b0;
        exp_n = (count > 4'd8) ? 8 : int'(count);
        ack_q.delete();
        seq_start = cyc; pushes_obs = 0; first_push_cyc = -1;
        start_cyc = -1; last_ack_cyc = -1; launch_cyc = -1;
        for (int i = 0; i < 800 && !finished; i++) begin
            applyStimulus(!started, count);
            if (ph == PH_IDLE && bus.launch_valid) started = 1'b1;
            stepCycle();
            if (started && ph == PH_IDLE) finished = 1'b1;
        end
        idleInputs();
        checkOutput("seq_finished", 32'(finished), 32'd1);
        checkOutput("push_count", 32'(pushes_obs), 32'(exp_n));
    endtask

    task automatic writeEntry(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idleInputs();
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_idx = 3'(idx);
        bus.cfg_wr_addr = a;
        bus.cfg_wr_data = d;
        stepCycle();
        idleInputs();
    endtask

    initial begin
        idleInputs();
        modelReset();
        rst = 1'b1;
        full_mode = 0; full_lo = 0; full_hi = 0; ack_mode = 0; ack_delay = 3; ack_hold = 0;
        busy_delay = 0; busy_len = 4; busy_in_start = 1'b0; noise = 1'b0;
        probe_cyc = -1; pushes_at_probe = 0; seq_start = 0;
        @(negedge clk);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        $display("[TB] directed three-entry launch");
        writeEntry(0, 8'h01, 32'h8000_0000);
        writeEntry(1, 8'h02, 32'h0000_0000);
        writeEntry(2, 8'h03, 32'h0000_0100);
        runSequence(4'd3);
        checkOutput("first_push_latency", 32'(first_push_cyc - launch_cyc), 32'd1);
        checkOutput("start_after_last_ack", 32'(start_cyc - last_ack_cyc), 32'd1);

        $display("[TB] eight entries with buffer_full window");
        for (int i = 0; i < 8; i++) writeEntry(i, AW'($urandom), $urandom);
        full_mode = 1; full_lo = 3; full_hi = 8; ack_delay = 2;
        runSequence(4'd8);
        full_mode = 0;

        $display("[TB] outstanding limit with acks withheld");
        ack_delay = 1; ack_hold = cyc + 30; probe_cyc = cyc + 25;
        runSequence(4'd8);
        checkOutput("stall_push_count", 32'(pushes_at_probe), 32'(MAX_OUT));
        ack_hold = 0; probe_cyc = -1;

        $display("[TB] spurious ack, count 12 and count 0");
        idleInputs();
        bus.dcr_ack = 1'b1;
        stepCycle();
        idleInputs();
        ack_delay = 2;
        runSequence(4'd12);
        runSequence(4'd0);
        checkOutput("zero_count_start", 32'(start_cyc - launch_cyc), 32'd1);

        $display("[TB] vx_busy during start cycle");
        busy_in_start = 1'b1; busy_delay = 1; busy_len = 3;
        runSequence(4'd2);
        busy_in_start = 1'b0;

        $display("[TB] randomized launches");
        noise = 1'b1; full_mode = 2;
        for (int k = 0; k < 8; k++) begin
            ack_mode = $urandom_range(0, 1);
            ack_delay = $urandom_range(1, 4);
            busy_delay = $urandom_range(0, 3);
            busy_len = $urandom_range(1, 5);
            busy_in_start = ($urandom_range(0, 1) == 1);
            runSequence(4'($urandom_range(0, 15)));
        end
        noise = 1'b0; full_mode = 0; ack_mode = 0; ack_delay = 3; busy_in_start = 1'b0;
        busy_delay = 0; busy_len = 4;

        $display("[TB] reset during push");
        for (int i = 0; i < 8; i++) writeEntry(i, AW'($urandom | 1), $urandom | 1);
        ack_q.delete();
        seq_start = cyc;
        for (int i = 0; i < 40; i++) begin
            if (ph == PH_SEND && m_sent == 2) break;
            applyStimulus(ph == PH_IDLE, 4'd5);
            stepCycle();
        end
        checkOutput("pre_reset_state", 32'(bus.seq_state), 32'(PH_SEND));
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_launch_ready", 32'(bus.launch_ready), 32'd1);
        checkOutput("rst_buffer_wr_valid", 32'(bus.buffer_wr_valid), 32'd0);
        checkOutput("rst_buffer_wr_addr", 32'(bus.buffer_wr_addr), 32'd0);
        checkOutput("rst_buffer_wr_data", bus.buffer_wr_data, 32'd0);
        checkOutput("rst_vx_start", 32'(bus.vx_start), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_seq_state", 32'(bus.seq_state), 32'd0);
        modelReset();
        idleInputs();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        stepCycle();
        ack_delay = 2;
        runSequence(4'd8);

`ifdef PITON_DCR_SEQ_TIMEOUT_EN
        $display("[TB] watchdog with vx_busy never asserted");
        busy_len = 0;
        runSequence(4'd0);
        busy_len = 4;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piton_dcr_seq_ctrl.md
Name: piton_dcr_seq_ctrl

Overview:
- Sequencer for the 8-entry Vortex DCR write buffer that sits between Piton core control and Vortex.
- Holds a host-programmed table of up to 8 DCR (addr, data) pairs and replays them into the DCR buffer on launch, respecting buffer_full and an outstanding-write limit.
- After all writes are acknowledged by Vortex, pulses vx_start, tracks vx_busy to completion, and raises done.

Parameters:
- VX_DCR_ADDR_WIDTH, 8, DCR address width
- VX_DCR_DATA_WIDTH, 32, DCR data width
- MAX_OUTSTANDING, 6, max pushed-but-unacknowledged writes (1..7)
- TIMEOUT_CYCLES, 65535, RUN-state watchdog limit (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_wr_valid  in  1  table entry write strobe
- cfg_wr_idx  in  3  table entry index
- cfg_wr_addr  in  VX_DCR_ADDR_WIDTH  entry DCR address
- cfg_wr_data  in  VX_DCR_DATA_WIDTH  entry DCR data
- launch_valid  in  1  launch request
- launch_count  in  4  number of table entries to send
- launch_ready  out  1  high in IDLE
- buffer_wr_valid  out  1  push to DCR buffer
- buffer_wr_addr  out  VX_DCR_ADDR_WIDTH  pushed address
- buffer_wr_data  out  VX_DCR_DATA_WIDTH  pushed data
- buffer_full  in  1  DCR buffer full
- dcr_ack  in  1  one-cycle pulse per DCR write accepted by Vortex (valid && rdy at buffer output)
- vx_start  out  1  one-cycle kernel start pulse
- vx_busy  in  1  Vortex busy
- done  out  1  sequence complete, sticky
- done_clr  in  1  clears done, returns to IDLE
- timeout_err  out  1  watchdog fired (0 without optional feature)
- seq_state  out  3  current FSM state encoding

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- Reset, including mid-operation, forces:
  - state IDLE; table entries, entry pointer, outstanding counter, busy_seen and timeout counter cleared to 0.
  - All outputs 0 except launch_ready=1.
- Table writes:
  - cfg_wr_valid writes entry[cfg_wr_idx] at the next clock, only in IDLE or DONE.
  - Ignored in every other state.
- State encodings: IDLE=0, PUSH=1, DRAIN=2, START=3, RUN=4, DONE=5.
- IDLE:
  - launch_ready=1.
  - On launch_valid, latch N = min(launch_count, 8) and set pointer=0.
  - N=0 goes to START; otherwise goes to PUSH.
- PUSH:
  - buffer_wr_valid is combinational: ~buffer_full && outstanding < MAX_OUTSTANDING.
  - buffer_wr_addr/buffer_wr_data = entry[pointer] whenever in PUSH.
  - At most one push per cycle; on a push, pointer increments.
  - Push of entry N-1 moves to DRAIN next cycle.
- Outstanding counter:
  - +1 on push, -1 on dcr_ack, unchanged when both occur in the same cycle.
  - dcr_ack while counter=0 is ignored (no underflow).
- DRAIN: wait until outstanding==0, then go to START.
- START: vx_start=1 for exactly one cycle, then go to RUN.
- RUN:
  - busy_seen is set when vx_busy=1.
  - Go to DONE on the first cycle where busy_seen==1 and vx_busy==0.
  - vx_busy already high in the START cycle is not counted; only RUN cycles count.
- DONE:
  - done=1 (registered) until done_clr; done_clr moves to IDLE next cycle with done=0.
  - launch_valid in DONE is ignored.
  - done_clr outside DONE is ignored.
- Latency:
  - First push occurs in the cycle after launch acceptance.
  - With no backpressure, N entries push in N consecutive cycles.
- launch_valid outside IDLE is ignored.

Optional Feature:
- Macro: PITON_DCR_SEQ_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in RUN, reset on entry.
  - If it reaches TIMEOUT_CYCLES before completion, go to DONE with timeout_err=1 and done=1.
  - done_clr clears both.
- When not defined: no counter, timeout_err tied to 0, RUN waits indefinitely.

Test Plan:
- Program entries 0..2 = (0x01,0x80000000), (0x02,0x0), (0x03,0x100); launch_count=3, no backpressure, dcr_ack 3 cycles after each push -> three consecutive pushes in that order, vx_start pulses one cycle after the third ack, done after vx_busy 1->0.
- launch_count=8 with buffer_full held high for 5 cycles mid-stream -> no push while full, all 8 entries delivered in order without loss or duplication.
- MAX_OUTSTANDING=6, launch_count=8, dcr_ack withheld -> exactly 6 pushes then stall; each later ack releases one push.
- launch_count=0 -> no buffer_wr_valid, vx_start one cycle after launch; launch_count=12 -> exactly 8 pushes.
- Assert rst in PUSH after 2 of 5 pushes -> outputs 0 immediately, launch_ready=1, table reads all zeros afterwards.
- With PITON_DCR_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, vx_busy never asserted -> done=1 and timeout_err=1 after 100 RUN cycles; done_clr returns to IDLE with both 0.
